fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
Parametrised synchronous single-clock FIFO, the successor to the fixed 24-bit x 4 tile buffer. Adds configurable width and depth, a level output, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and a synchronous flush. It sits between tile producers and consumers in the same clock domain. It is a drop-in replacement when DATA_W=24 and DEPTH=4.

Parameters:
DATA_W, 24, data word width in bits (>=1)
DEPTH, 4, number of entries; power of two, >=2
AF_LEVEL, 3, almost_full asserts when level >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when level <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous flush; empties FIFO, keeps error flags
data_in  input  DATA_W  write data
push  input  1  write request
pop  input  1  read request
data_out  output  DATA_W  read data (registered)
rd_valid  output  1  one-cycle pulse: data_out updated by accepted pop
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
empty  output  1  level==0
full  output  1  level==DEPTH
almost_empty  output  1  level<=AE_LEVEL
almost_full  output  1  level>=AF_LEVEL
overflow  output  1  sticky: push rejected while full
underflow  output  1  sticky: pop rejected while empty
err_clr  input  1  synchronous clear of overflow and underflow

Behaviour:
- Reset (async, immediate):
  - write_ptr, read_ptr, level = 0; data_out = 0; rd_valid = 0.
  - empty = 1; full = 0; almost_empty = 1; almost_full = (AF_LEVEL==0 ? 1 : 0), which is effectively 0.
  - overflow = 0; underflow = 0.
  - Storage array contents are not reset.
- Pointers: log2(DEPTH) bits each; they wrap naturally from DEPTH-1 to 0.
- Pop acceptance: pop_ok = pop && level!=0.
- Push acceptance: push_ok = push && (level!=DEPTH || pop_ok). A push to a full FIFO with a simultaneous accepted pop is accepted.
- Empty FIFO with push and pop together:
  - Push is accepted, pop is rejected, underflow is set.
  - The written word is not bypassed to data_out.
- Accepted push: mem[write_ptr] <= data_in; write_ptr increments.
- Accepted pop: data_out <= mem[read_ptr] at the next clock edge (1-cycle latency); read_ptr increments; rd_valid = 1 for that cycle. Otherwise rd_valid = 0 and data_out holds its value.
- Level update: level_next = level + push_ok - pop_ok.
  - Simultaneous accepted push and pop leaves level unchanged.
  - Level never exceeds DEPTH and never goes below 0.
- Flags are registered and computed from level_next, so they are valid in the same cycle as level.
- Error flags:
  - overflow <= 1 on push && !push_ok.
  - underflow <= 1 on pop && !pop_ok.
  - Both hold until err_clr or reset. If err_clr and a new error coincide, set wins.
- clear:
  - Pointers and level go to 0; flags take their empty values; rd_valid = 0.
  - data_out is held.
  - push and pop in the same cycle are ignored and do not flag errors.
  - clear has priority over push and pop.
- Read-during-write to the same entry cannot occur except on full+push+pop. In that case the pop reads the old word, which is required ordering.

Optional Feature:
Macro FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out continuously presents mem[read_ptr] when !empty; pop acknowledges and advances.
  - Zero read latency; rd_valid = !empty.
  - A word becomes visible the cycle after its push is accepted.
- Undefined: the registered 1-cycle-latency read behaviour described above.

Test Plan:
- Reset, then push 0xA00001..0xA00004 (DEPTH=4):
  - level steps 1,2,3,4.
  - almost_full rises when level=3; full rises when level=4; overflow stays 0.
- From full, push 0xA00005 alone -> rejected, overflow=1, level stays 4. Then err_clr -> overflow=0.
- Full, push 0xB00000 with pop in the same cycle:
  - Next cycle data_out=0xA00001, rd_valid=1, level=4.
  - Later drains return A00002, A00003, A00004, B00000 in order.
- Empty, pop alone -> underflow=1, rd_valid=0, data_out unchanged. Empty with push 0x000123 and pop -> level=1, underflow=1.
- Four-entry wrap test: interleave push and pop for 10 words 0..9 -> outputs 0..9 in order, level bounded 0..2, pointers wrap with no corruption.
- Mid-operation tests:
  - level=3 with clear -> level=0, empty=1, overflow unchanged.
  - Async reset asserted between clock edges at level=2 -> all outputs reset immediately without waiting for a clock edge.
  - With FIFO_FWFT_EN defined: push 0x5A5A5A -> data_out=0x5A5A5A on the next cycle with no pop.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with level, almost flags, sticky errors and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered read.
module fifo_sync_param #(
  parameter int DATA_W   = 24,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   push,
  input  logic                   pop,
  output logic [DATA_W-1:0]      data_out,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE  = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] LVL_AE   = LW'(AE_LEVEL);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic              ae_q, ae_d, af_q, af_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              pop_ok_s, push_ok_s, wr_en_s, rd_en_s;

  // Acceptance, next pointers/level, and flags derived from the next level
  always_comb begin
    pop_ok_s  = pop && (level_q != LVL_ZERO);
    push_ok_s = push && ((level_q != LVL_FULL) || pop_ok_s);
    wr_en_s   = push_ok_s && !clear;
    rd_en_s   = pop_ok_s && !clear;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (clear) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      level_d  = LVL_ZERO;
    end else begin
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
    // A new error in the same cycle as err_clr must survive the clear
    ovf_d   = (ovf_q && !err_clr) || (!clear && push && !push_ok_s);
    udf_d   = (udf_q && !err_clr) || (!clear && pop && !pop_ok_s);
    empty_d = (level_d == LVL_ZERO);
    full_d  = (level_d == LVL_FULL);
    ae_d    = (level_d <= LVL_AE);
    af_d    = (level_d >= LVL_AF);
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      level_q  <= LVL_ZERO;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= (LVL_AF == LVL_ZERO);
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out = empty_q ? {DATA_W{1'b0}} : mem_q[rd_ptr_q];
  assign rd_valid = !empty_q;
`else
  logic [DATA_W-1:0] dout_q;
  logic              rd_valid_q;

  // Registered read port; the non-blocking read returns the old word on full push+pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q     <= {DATA_W{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      if (rd_en_s) begin
        dout_q <= mem_q[rd_ptr_q];
      end
      rd_valid_q <= rd_en_s;
    end
  end

  assign data_out = dout_q;
  assign rd_valid = rd_valid_q;
`endif

  assign level        = level_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param at the default 24-bit x 4 configuration.
module tb_fifo_sync_param;

  logic        clk = 1'b0;
  logic        reset, clear, push, pop, err_clr;
  logic [23:0] data_in;
  logic [23:0] data_out;
  logic        rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [2:0]  level;
  int          n_cmp = 0;
  int          n_fail = 0;

  fifo_sync_param dut (
    .clk(clk), .reset(reset), .clear(clear), .data_in(data_in), .push(push), .pop(pop),
    .data_out(data_out), .rd_valid(rd_valid), .level(level), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic ps, input logic pp, input logic [23:0] d,
                     input logic clr, input logic ec);
    push = ps; pop = pp; data_in = d; clear = clr; err_clr = ec;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; data_in = 24'h0; clear = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; data_in = 24'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_rdv", rd_valid, 0);

    // fill
    cyc(1'b1, 1'b0, 24'hA00001, 1'b0, 1'b0);
    chk("f1_level", level, 1); chk("f1_ae", almost_empty, 1); chk("f1_empty", empty, 0);
    cyc(1'b1, 1'b0, 24'hA00002, 1'b0, 1'b0);
    chk("f2_level", level, 2); chk("f2_ae", almost_empty, 0); chk("f2_af", almost_full, 0);
    cyc(1'b1, 1'b0, 24'hA00003, 1'b0, 1'b0);
    chk("f3_level", level, 3); chk("f3_af", almost_full, 1); chk("f3_full", full, 0);
    cyc(1'b1, 1'b0, 24'hA00004, 1'b0, 1'b0);
    chk("f4_level", level, 4); chk("f4_full", full, 1); chk("f4_ovf", overflow, 0);

    // overflow, then clear it
    cyc(1'b1, 1'b0, 24'hA00005, 1'b0, 1'b0);
    chk("ovf_set", overflow, 1); chk("ovf_level", level, 4); chk("ovf_rdv", rd_valid, 0);
    cyc(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
    chk("ovf_clr", overflow, 0); chk("ovf_clr_level", level, 4);

    // full push + pop
    cyc(1'b1, 1'b1, 24'hB00000, 1'b0, 1'b0);
    chk("fpp_dout", data_out, 24'hA00001); chk("fpp_rdv", rd_valid, 1);
    chk("fpp_level", level, 4); chk("fpp_ovf", overflow, 0);
    cyc(1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
    chk("dr1_dout", data_out, 24'hA00002); chk("dr1_level", level, 3);
    cyc(1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
    chk("dr2_dout", data_out, 24'hA00003); chk("dr2_level", level, 2);
    cyc(1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
    chk("dr3_dout", data_out, 24'hA00004); chk("dr3_level", level, 1);
    cyc(1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
    chk("dr4_dout", data_out, 24'hB00000); chk("dr4_level", level, 0);
    chk("dr4_empty", empty, 1); chk("dr4_rdv", rd_valid, 1);
    cyc(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    chk("idle_rdv", rd_valid, 0); chk("idle_dout", data_out, 24'hB00000);

    // underflow
    cyc(1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
    chk("udf_set", underflow, 1); chk("udf_rdv", rd_valid, 0); chk("udf_dout", data_out, 24'hB00000);
    cyc(1'b1, 1'b1, 24'h000123, 1'b0, 1'b0);
    chk("epp_level", level, 1); chk("epp_udf", underflow, 1);
    chk("epp_rdv", rd_valid, 0); chk("epp_dout", data_out, 24'hB00000);
    cyc(1'b0, 1'b1, 24'h0, 1'b0, 1'b1);
    chk("udfclr_udf", underflow, 0); chk("udfclr_dout", data_out, 24'h000123);
    chk("udfclr_level", level, 0);
    cyc(1'b0, 1'b1, 24'h0, 1'b0, 1'b1);
    chk("setwins_udf", underflow, 1);
    cyc(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
    chk("udfclr2_udf", underflow, 0);

    // wrap: interleaved push/pop of 0..9
    cyc(1'b1, 1'b0, 24'd0, 1'b0, 1'b0);
    chk("wrap_level0", level, 1);
    for (int i = 1; i < 10; i++) begin
      cyc(1'b1, 1'b1, 24'(i), 1'b0, 1'b0);
      chk("wrap_dout", data_out, 32'(i - 1));
      chk("wrap_level", level, 1);
    end
    cyc(1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
    chk("wrap_last", data_out, 9); chk("wrap_end_level", level, 0);

    // clear mid-operation
    cyc(1'b1, 1'b0, 24'hC00001, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 24'hC00002, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 24'hC00003, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 24'hC00004, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 24'hC00005, 1'b0, 1'b0);
    chk("pre_clr_ovf", overflow, 1);
    cyc(1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
    chk("pre_clr_level", level, 3); chk("pre_clr_dout", data_out, 24'hC00001);
    cyc(1'b1, 1'b1, 24'hD00000, 1'b1, 1'b0);
    chk("clr_level", level, 0); chk("clr_empty", empty, 1); chk("clr_full", full, 0);
    chk("clr_af", almost_full, 0); chk("clr_ae", almost_empty, 1);
    chk("clr_ovf", overflow, 1); chk("clr_udf", underflow, 0);
    chk("clr_rdv", rd_valid, 0); chk("clr_dout", data_out, 24'hC00001);
    cyc(1'b1, 1'b0, 24'hE00001, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
    chk("postclr_dout", data_out, 24'hE00001); chk("postclr_level", level, 0);

    // async reset between edges
    cyc(1'b1, 1'b0, 24'hF00001, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 24'hF00002, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 24'hF00003, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
    chk("pre_ar_level", level, 2); chk("pre_ar_dout", data_out, 24'hF00001);
    #2 reset = 1'b1;
    #1;
    chk("ar_level", level, 0); chk("ar_empty", empty, 1); chk("ar_dout", data_out, 0);
    chk("ar_ovf", overflow, 0); chk("ar_ae", almost_empty, 1); chk("ar_rdv", rd_valid, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(1'b1, 1'b0, 24'h111111, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
    chk("post_ar_dout", data_out, 24'h111111); chk("post_ar_level", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
